// File: rtl/apb_icn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_icn_pkg
// Purpose  : Shared types for the APB crossbar requester front end: the
//            requester FSM state encoding and the packed command flit.
// Revision : 1.0
// ============================================================================
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package apb_icn_pkg;

    localparam int APB_ADDR_W  = `ADDR_WIDTH;
    localparam int APB_DATA_W  = `DATA_WIDTH;
    localparam int APB_STRB_W  = APB_DATA_W / 8;
    localparam int APB_STATE_W = 2;

    typedef enum logic [APB_STATE_W-1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    // Field order matches the crossbar request flit.
    typedef struct packed {
        logic [APB_ADDR_W-1:0] addr;
        logic                  write;
        logic [APB_DATA_W-1:0] wdata;
        logic [APB_STRB_W-1:0] strb;
        logic [2:0]            prot;
        logic                  nse;
    } apb_cmd_t;

endpackage
`default_nettype wire

// File: rtl/apb_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module   : apb_cmd_fifo
// Purpose  : Synchronous command FIFO with wrap-bit pointers, async
//            active-low reset.
// Revision : 1.0
// ============================================================================
module apb_cmd_fifo
    import apb_icn_pkg::*;
#(
    parameter int WIDTH = $bits(apb_cmd_t),
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Equal indices: same wrap bit means empty, differing wrap bit means full.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/apb_cmd_requester.sv
`default_nettype none
// ============================================================================
// Module   : apb_cmd_requester
// Purpose  : Queues memory commands and drives them as APB transfers into one
//            crossbar requester port; returns a single-entry response.
//            Optional ACCESS timeout enabled by macro APB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module apb_cmd_requester
    import apb_icn_pkg::*;
#(
    parameter int ADDR_WIDTH     = APB_ADDR_W,
    parameter int DATA_WIDTH     = APB_DATA_W,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      pclk,
    input  logic                      preset_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic                      cmd_write,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_strb,
    input  logic [2:0]                cmd_prot,
    input  logic                      cmd_nse,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_slverr,
    output logic [ADDR_WIDTH-1:0]     paddr,
    output logic [2:0]                pprot,
    output logic                      pnse,
    output logic                      pwrite,
    output logic [DATA_WIDTH-1:0]     pwdata,
    output logic [DATA_WIDTH/8-1:0]   pstrb,
    output logic                      psel,
    output logic                      penable,
    input  logic                      pready,
    input  logic [DATA_WIDTH-1:0]     prdata,
    input  logic                      pslverr,
    output logic                      pwakeup
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CMD_W  = ADDR_WIDTH + 1 + DATA_WIDTH + STRB_W + 3 + 1;

    apb_state_e              state_q, state_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [2:0]              pprot_q, pprot_d;
    logic                    pnse_q, pnse_d;
    logic                    pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [STRB_W-1:0]       pstrb_q, pstrb_d;
    logic                    psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_slverr_q, rsp_slverr_d;
    logic                    pwakeup_q, pwakeup_d;

    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CMD_W-1:0]        fifo_push_data;
    logic [CMD_W-1:0]        fifo_pop_data;

`ifdef APB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
    logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
`endif

    // Packing order mirrors apb_cmd_t.
    assign fifo_push      = cmd_valid && cmd_ready;
    assign fifo_push_data = {cmd_addr, cmd_write, cmd_wdata, cmd_strb, cmd_prot, cmd_nse};
    assign cmd_ready      = !fifo_full;

    apb_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (pclk),
        .rst_n     (preset_n),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        paddr_d      = paddr_q;
        pprot_d      = pprot_q;
        pnse_d       = pnse_q;
        pwrite_d     = pwrite_q;
        pwdata_d     = pwdata_q;
        pstrb_d      = pstrb_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_slverr_d = rsp_slverr_q;
        fifo_pop     = 1'b0;
`ifdef APB_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
`endif
        pwakeup_d    = !fifo_empty || (state_q != ST_IDLE) || cmd_valid;

        if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Issue only if the response slot is free or drains this edge.
                if (!fifo_empty && (!rsp_valid_q || rsp_ready)) begin
                    fifo_pop = 1'b1;
                    {paddr_d, pwrite_d, pwdata_d, pstrb_d, pprot_d, pnse_d} = fifo_pop_data;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
`ifdef APB_TIMEOUT_EN
                to_cnt_d  = '0;
`endif
            end
            ST_ACCESS: begin
                if (pready) begin
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    state_d      = ST_IDLE;
                    rsp_valid_d  = 1'b1;
                    rsp_rdata_d  = pwrite_q ? '0 : prdata;
                    rsp_slverr_d = pslverr;
                end
`ifdef APB_TIMEOUT_EN
                else if (to_cnt_q == TO_LIMIT) begin
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    state_d      = ST_IDLE;
                    rsp_valid_d  = 1'b1;
                    rsp_rdata_d  = '0;
                    rsp_slverr_d = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d   = ST_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q      <= ST_IDLE;
            paddr_q      <= '0;
            pprot_q      <= '0;
            pnse_q       <= 1'b0;
            pwrite_q     <= 1'b0;
            pwdata_q     <= '0;
            pstrb_q      <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_slverr_q <= 1'b0;
            pwakeup_q    <= 1'b0;
`ifdef APB_TIMEOUT_EN
            to_cnt_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            paddr_q      <= paddr_d;
            pprot_q      <= pprot_d;
            pnse_q       <= pnse_d;
            pwrite_q     <= pwrite_d;
            pwdata_q     <= pwdata_d;
            pstrb_q      <= pstrb_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_slverr_q <= rsp_slverr_d;
            pwakeup_q    <= pwakeup_d;
`ifdef APB_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
`endif
        end
    end

    assign paddr      = paddr_q;
    assign pprot      = pprot_q;
    assign pnse       = pnse_q;
    assign pwrite     = pwrite_q;
    assign pwdata     = pwdata_q;
    assign pstrb      = pstrb_q;
    assign psel       = psel_q;
    assign penable    = penable_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_slverr = rsp_slverr_q;
    assign pwakeup    = pwakeup_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_cmd_requester.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_cmd_requester
// Purpose  : Directed and randomized self-checking bench for apb_cmd_requester.
// Revision : 1.0
// ============================================================================
module tb_apb_cmd_requester;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT_CYCLES = 8;

    logic          pclk;
    logic          preset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic          cmd_write;
    logic [DW-1:0] cmd_wdata;
    logic [3:0]    cmd_strb;
    logic [2:0]    cmd_prot;
    logic          cmd_nse;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_slverr;
    logic [AW-1:0] paddr;
    logic [2:0]    pprot;
    logic          pnse;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic [3:0]    pstrb;
    logic          psel;
    logic          penable;
    logic          pready;
    logic [DW-1:0] prdata;
    logic          pslverr;
    logic          pwakeup;

    apb_cmd_requester #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .FIFO_DEPTH     (FIFO_DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .pclk       (pclk),
        .preset_n   (preset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_write  (cmd_write),
        .cmd_wdata  (cmd_wdata),
        .cmd_strb   (cmd_strb),
        .cmd_prot   (cmd_prot),
        .cmd_nse    (cmd_nse),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_slverr (rsp_slverr),
        .paddr      (paddr),
        .pprot      (pprot),
        .pnse       (pnse),
        .pwrite     (pwrite),
        .pwdata     (pwdata),
        .pstrb      (pstrb),
        .psel       (psel),
        .penable    (penable),
        .pready     (pready),
        .prdata     (prdata),
        .pslverr    (pslverr),
        .pwakeup    (pwakeup)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic          w;
        logic [DW-1:0] wd;
        logic [3:0]    st;
        logic [2:0]    prot;
        logic          nse;
    } tcmd_t;

    // Reference model of the requester as seen from its ports.
    tcmd_t         pend[$];
    tcmd_t         cur;
    tcmd_t         nc;
    bit            busy, have_cur, ev, ev_err, exp_wake;
    bit            consume, issue, done, accept, acc_now;
    int            age;
    logic [DW-1:0] ev_rdata;
    int            k, seen, resp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic wait_penable();
        for (int i = 0; i < 20 && !(psel && penable); i++) tick();
        chk("wait_penable", {62'd0, psel, penable}, 64'd3);
    endtask

    // One isolated transfer from an idle requester with exact timing checks.
    task automatic xfer(input string tag, input logic [31:0] a, input logic w,
                        input logic [31:0] wd, input logic [3:0] st, input int waits,
                        input logic [31:0] rd, input logic err);
        cmd_valid = 1'b1; cmd_addr = a; cmd_write = w; cmd_wdata = wd;
        cmd_strb = st; cmd_prot = 3'b010; cmd_nse = 1'b0;
        rsp_ready = 1'b1; pready = 1'b0; prdata = rd; pslverr = err;
        chk({tag, "_cmd_ready"}, cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        chk({tag, "_psel_after_accept"}, psel, 0);
        tick();
        chk({tag, "_setup"}, {psel, penable, pwrite}, {1'b1, 1'b0, w});
        chk({tag, "_setup_fields"}, {paddr, pwdata}, {a, wd});
        chk({tag, "_setup_strb"}, {pstrb, pprot}, {st, 3'b010});
        tick();
        for (int i = 0; i <= waits; i++) begin
            chk({tag, "_access"}, {psel, penable, rsp_valid}, 3'b110);
            chk({tag, "_access_fields"}, {paddr, pwdata}, {a, wd});
            if (i == waits) pready = 1'b1;
            tick();
        end
        pready = 1'b0;
        chk({tag, "_done_ctl"}, {psel, penable, rsp_valid}, 3'b001);
        chk({tag, "_rdata"}, rsp_rdata, w ? 32'd0 : rd);
        chk({tag, "_slverr"}, rsp_slverr, err);
        tick();
        chk({tag, "_rsp_cleared"}, rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_valid = 0; cmd_addr = 0; cmd_write = 0; cmd_wdata = 0; cmd_strb = 0;
        cmd_prot = 0; cmd_nse = 0; rsp_ready = 0; pready = 0; prdata = 0; pslverr = 0;
        preset_n = 1'b1;
        #2 preset_n = 1'b0;
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_ctl", {psel, penable, rsp_valid, rsp_slverr, pwakeup}, 5'b0);
        chk("rst_fields", {paddr, pwdata, pwrite, pstrb}, 69'd0);
        tick(); tick();
        preset_n = 1'b1;
        tick();

        xfer("wr", 32'h10, 1'b1, 32'hA5A5_0001, 4'hF, 0, 32'h1234_5678, 1'b0);
        xfer("rd_wait", 32'h20, 1'b0, 32'h0, 4'h0, 3, 32'hDEAD_BEEF, 1'b0);
        xfer("err_wr", 32'h30, 1'b1, 32'h5555_AAAA, 4'h3, 0, 32'h0, 1'b1);
        xfer("after_err", 32'h34, 1'b0, 32'h0, 4'h0, 1, 32'h0BAD_F00D, 1'b0);
        chk("hold_fields", {paddr, pwrite}, {32'h34, 1'b0});

        // Backpressure: stalled response fills the FIFO behind one issue.
        rsp_ready = 1'b0; pready = 1'b1; pslverr = 1'b0; k = 0;
        for (int c = 0; c < 10; c++) begin
            cmd_valid = (k < 6); cmd_addr = 32'h100 + 32'(k * 4);
            cmd_write = 1'b1; cmd_wdata = 32'(k); cmd_strb = 4'hF;
            acc_now = cmd_valid && cmd_ready;
            tick();
            if (acc_now) k++;
        end
        chk("bp_accepted", k, 5);
        chk("bp_cmd_ready", cmd_ready, 0);
        chk("bp_no_issue", psel, 0);
        chk("bp_rsp_held", {rsp_valid, rsp_slverr}, 2'b10);
        chk("bp_first_addr", paddr, 32'h100);
        rsp_ready = 1'b1; seen = 1; resp = 0;
        for (int c = 0; c < 80 && resp < 6; c++) begin
            cmd_valid = (k < 6); cmd_addr = 32'h100 + 32'(k * 4); cmd_wdata = 32'(k);
            if (psel && !penable) begin
                chk("bp_order", paddr, 32'h100 + 32'(seen * 4));
                seen++;
            end
            if (rsp_valid) resp++;
            acc_now = cmd_valid && cmd_ready;
            tick();
            if (acc_now) k++;
        end
        cmd_valid = 1'b0;
        chk("bp_all_issued", seen, 6);
        chk("bp_all_rsp", resp, 6);
        tick(); tick();

        // Asynchronous reset in the middle of an ACCESS phase.
        pready = 1'b0; rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1; cmd_addr = 32'h200 + 32'(i); cmd_write = 1'b0;
            tick();
        end
        cmd_valid = 1'b0;
        wait_penable();
        preset_n = 1'b0;
        #1;
        chk("arst_ctl", {psel, penable, rsp_valid}, 3'b000);
        chk("arst_cmd_ready", cmd_ready, 1);
        @(posedge pclk); #1;
        preset_n = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("arst_fifo_empty", {psel, pwakeup, cmd_ready}, 3'b001);

        // ACCESS with pready held low.
        cmd_valid = 1'b1; cmd_addr = 32'h300; cmd_write = 1'b0; prdata = 32'hCAFE_0001;
        tick();
        cmd_valid = 1'b0;
        wait_penable();
`ifdef APB_TIMEOUT_EN
        k = 0;
        while (!rsp_valid && k < 100) begin tick(); k++; end
        chk("to_cycles", k, TIMEOUT_CYCLES + 1);
        chk("to_rsp", {psel, penable, rsp_valid, rsp_slverr}, 4'b0011);
        chk("to_rdata", rsp_rdata, 0);
`else
        for (int i = 0; i < 40; i++) tick();
        chk("noto_held", {psel, penable, rsp_valid}, 3'b110);
        pready = 1'b1;
        tick();
        pready = 1'b0;
        chk("noto_done", {psel, rsp_valid, rsp_slverr}, 3'b010);
        chk("noto_rdata", rsp_rdata, 32'hCAFE_0001);
`endif
        tick(); tick(); tick();

        // Randomized traffic against the port-level model.
        pend.delete(); busy = 0; have_cur = 0; ev = 0; exp_wake = 0; age = 0;
        for (int n = 0; n < 500; n++) begin
            chk("r_cmd_ready", cmd_ready, pend.size() < FIFO_DEPTH);
            chk("r_psel_penable", {psel, penable}, {busy, busy && age >= 1});
            chk("r_rsp_valid", rsp_valid, ev);
            if (ev) chk("r_rsp", {rsp_rdata, rsp_slverr}, {ev_rdata, ev_err});
            chk("r_pwakeup", pwakeup, exp_wake);
            if (have_cur) begin
                chk("r_addr_wr", {paddr, pwrite, pwdata}, {cur.addr, cur.w, cur.wd});
                chk("r_strb_prot", {pstrb, pprot, pnse}, {cur.st, cur.prot, cur.nse});
            end

            cmd_valid = ($urandom % 3) != 0;
            cmd_addr  = $urandom; cmd_write = 1'($urandom); cmd_wdata = $urandom;
            cmd_strb  = 4'($urandom); cmd_prot = 3'($urandom); cmd_nse = 1'($urandom);
            rsp_ready = ($urandom % 4) != 0;
            pready    = ($urandom % 3) == 0;
            prdata    = $urandom;
            pslverr   = ($urandom % 5) == 0;

            exp_wake = (pend.size() != 0) || busy || cmd_valid;
            accept   = cmd_valid && (pend.size() < FIFO_DEPTH);
            consume  = ev && rsp_ready;
            issue    = !busy && (pend.size() != 0) && (!ev || rsp_ready);
            done     = busy && age >= 1 && pready;
            if (consume) ev = 0;
            if (done) begin
                busy = 0; ev = 1; ev_err = pslverr;
                ev_rdata = cur.w ? 32'd0 : prdata;
            end
`ifdef APB_TIMEOUT_EN
            else if (busy && age >= 1 && (age - 1) == TIMEOUT_CYCLES) begin
                busy = 0; ev = 1; ev_err = 1; ev_rdata = 32'd0;
            end
`endif
            else if (busy) age++;
            if (issue) begin
                cur = pend.pop_front(); busy = 1; age = 0; have_cur = 1;
            end
            if (accept) begin
                nc.addr = cmd_addr; nc.w = cmd_write; nc.wd = cmd_wdata;
                nc.st = cmd_strb; nc.prot = cmd_prot; nc.nse = cmd_nse;
                pend.push_back(nc);
            end
            tick();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
